// File: rtl/counter_pkg.sv
// Shared types and 7-segment glyph table for the up/down digit counter.
// Glyph bit order is {a,b,c,d,e,f,g}, active-low.
package counter_pkg;

   typedef logic [3:0] digit_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] GLYPH [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

endpackage

// File: rtl/seg_scan_mux.sv
// Multiplexed common-anode scan: divider, digit index, anode decode and glyph lookup.
// Optional LZ_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_scan_mux #(
   parameter int N_DIGITS = 4,
   parameter int SCAN_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic [4*N_DIGITS-1:0] count,
   output logic [6:0]            seg,
   output logic [N_DIGITS-1:0]   an
);
   import counter_pkg::*;

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   logic [CNT_W-1:0]    scan_cnt;
   logic [IDX_W-1:0]    idx;
   digit_t              cur;
   logic [6:0]          seg_next;
   logic [N_DIGITS-1:0] an_next;

   always_comb begin
      cur      = count[{idx, 2'b00} +: 4];
      an_next  = ~(N_DIGITS'(1) << idx);
      seg_next = GLYPH[cur];
`ifdef LZ_BLANK_EN
      if (idx != '0 && (count >> {idx, 2'b00}) == '0)
         seg_next = SEG_BLANK;
`else
`endif
   end

   // Anode and glyph latch together with the index step, so they never disagree.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         scan_cnt <= '0;
         idx      <= '0;
         an       <= '1;
         seg      <= SEG_BLANK;
      end else if (scan_cnt == CNT_LAST) begin
         scan_cnt <= '0;
         idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         an       <= an_next;
         seg      <= seg_next;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/updown_digit_counter.sv
// N-digit up/down counter (BCD or hex digits) with wrap/saturate, parallel load and
// built-in 7-segment scan. Define LZ_BLANK_EN to blank leading zero digits.
module updown_digit_counter #(
   parameter int N_DIGITS  = 4,
   parameter int RADIX     = 10,
   parameter int RESET_VAL = 3,
   parameter int WRAP      = 1,
   parameter int SCAN_DIV  = 100000
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  step_valid,
   input  logic                  dir_up,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] load_val,
   output logic [4*N_DIGITS-1:0] count,
   output logic                  ovf,
   output logic                  unf,
   output logic                  a,
   output logic                  b,
   output logic                  c,
   output logic                  d,
   output logic                  e,
   output logic                  f,
   output logic                  g,
   output logic                  dp,
   output logic [N_DIGITS-1:0]   an
);
   import counter_pkg::*;

   localparam int W = 4 * N_DIGITS;
   localparam digit_t DMAX = digit_t'(RADIX - 1);

   function automatic logic [W-1:0] to_digits(input int val);
      logic [W-1:0] r;
      int           v;
      r = '0;
      v = val;
      for (int i = 0; i < N_DIGITS; i++) begin
         r[i*4 +: 4] = digit_t'(v % RADIX);
         v = v / RADIX;
      end
      return r;
   endfunction

   localparam logic [W-1:0] RESET_DIGITS = to_digits(RESET_VAL);

   function automatic logic [W-1:0] clamp_load(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < N_DIGITS; i++)
         if (v[i*4 +: 4] > DMAX) r[i*4 +: 4] = DMAX;
      return r;
   endfunction

   // MSB of the result is the carry out of the top digit, i.e. "was at maximum".
   function automatic logic [W:0] step_up(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         carry;
      digit_t       dg;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < N_DIGITS; i++) begin
         dg = v[i*4 +: 4];
         if (carry) begin
            if (dg == DMAX) dg = '0;
            else begin
               dg    = dg + 1'b1;
               carry = 1'b0;
            end
         end
         r[i*4 +: 4] = dg;
      end
      return {carry, r};
   endfunction

   function automatic logic [W:0] step_down(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      digit_t       dg;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < N_DIGITS; i++) begin
         dg = v[i*4 +: 4];
         if (borrow) begin
            if (dg == '0) dg = DMAX;
            else begin
               dg     = dg - 1'b1;
               borrow = 1'b0;
            end
         end
         r[i*4 +: 4] = dg;
      end
      return {borrow, r};
   endfunction

   logic [W:0] up_next;
   logic [W:0] dn_next;
   logic [6:0] seg;

   assign up_next = step_up(count);
   assign dn_next = step_down(count);

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         count <= RESET_DIGITS;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         ovf <= 1'b0;
         unf <= 1'b0;
         if (load) begin
            count <= clamp_load(load_val);
         end else if (step_valid) begin
            if (dir_up) begin
               ovf <= up_next[W];
               if (!up_next[W] || WRAP != 0) count <= up_next[W-1:0];
            end else begin
               unf <= dn_next[W];
               if (!dn_next[W] || WRAP != 0) count <= dn_next[W-1:0];
            end
         end
      end
   end

   seg_scan_mux #(
      .N_DIGITS(N_DIGITS),
      .SCAN_DIV(SCAN_DIV)
   ) u_scan (
      .clk  (clk),
      .res  (res),
      .count(count),
      .seg  (seg),
      .an   (an)
   );

   assign {a, b, c, d, e, f, g} = seg;
   assign dp = 1'b1;

endmodule

// File: tb/tb_updown_digit_counter.sv
// Bench for updown_digit_counter: a decimal wrapping instance and a hex saturating
// instance share one stimulus stream and are checked against table and integer model.
module tb_updown_digit_counter;

   localparam int SD = 4;

   logic        clk = 1'b0;
   logic        res;
   logic        step_valid;
   logic        dir_up;
   logic        load;
   logic [15:0] load_val;

   logic [15:0] count_d, count_h;
   logic        ovf_d, unf_d, ovf_h, unf_h;
   logic [6:0]  seg_d, seg_h;
   logic        dp_d, dp_h;
   logic [3:0]  an_d, an_h;

   updown_digit_counter #(.N_DIGITS(4), .RADIX(10), .RESET_VAL(3), .WRAP(1), .SCAN_DIV(SD)) dut (
      .clk(clk), .res(res), .step_valid(step_valid), .dir_up(dir_up), .load(load),
      .load_val(load_val), .count(count_d), .ovf(ovf_d), .unf(unf_d),
      .a(seg_d[6]), .b(seg_d[5]), .c(seg_d[4]), .d(seg_d[3]), .e(seg_d[2]), .f(seg_d[1]),
      .g(seg_d[0]), .dp(dp_d), .an(an_d));

   updown_digit_counter #(.N_DIGITS(4), .RADIX(16), .RESET_VAL(3), .WRAP(0), .SCAN_DIV(SD)) dut_h (
      .clk(clk), .res(res), .step_valid(step_valid), .dir_up(dir_up), .load(load),
      .load_val(load_val), .count(count_h), .ovf(ovf_h), .unf(unf_h),
      .a(seg_h[6]), .b(seg_h[5]), .c(seg_h[4]), .d(seg_h[3]), .e(seg_h[2]), .f(seg_h[1]),
      .g(seg_h[0]), .dp(dp_h), .an(an_h));

   always #5 clk = ~clk;

   int cyc;
   always @(posedge clk or posedge res)
      if (res) cyc <= 0;
      else     cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   int m10, m16;
   bit eo10, eu10, eo16, eu16;

   typedef struct {
      logic        ld;
      logic [15:0] lv;
      logic        st;
      logic        up;
      logic [15:0] ed;
      logic        od;
      logic        ud;
      logic [15:0] eh;
      logic        oh;
      logic        uh;
   } vec_t;

   vec_t tbl [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int maxv(input int r);
      return r * r * r * r - 1;
   endfunction

   function automatic logic [15:0] enc(input int v, input int r);
      logic [15:0] x;
      x = '0;
      for (int i = 0; i < 4; i++) begin
         x[i*4 +: 4] = 4'(v % r);
         v = v / r;
      end
      return x;
   endfunction

   function automatic int clampval(input logic [15:0] lv, input int r);
      int acc, w, dg;
      acc = 0;
      w   = 1;
      for (int i = 0; i < 4; i++) begin
         dg = int'(lv[i*4 +: 4]);
         if (dg > r - 1) dg = r - 1;
         acc += dg * w;
         w   *= r;
      end
      return acc;
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] dg);
      logic [6:0] p;
      case (dg)
         4'h0: p = 7'h7E; 4'h1: p = 7'h30; 4'h2: p = 7'h6D; 4'h3: p = 7'h79;
         4'h4: p = 7'h33; 4'h5: p = 7'h5B; 4'h6: p = 7'h5F; 4'h7: p = 7'h70;
         4'h8: p = 7'h7F; 4'h9: p = 7'h7B; 4'hA: p = 7'h77; 4'hB: p = 7'h1F;
         4'hC: p = 7'h4E; 4'hD: p = 7'h3D; 4'hE: p = 7'h4F; default: p = 7'h47;
      endcase
      return ~p;
   endfunction

   function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k);
`ifdef LZ_BLANK_EN
      if (k != 0 && (v >> (4 * k)) == 16'h0) return 7'h7F;
`else
`endif
      return glyph(v[k*4 +: 4]);
   endfunction

   task automatic model_step(inout int m, input int r, input bit wrap, input logic ld,
                             input logic [15:0] lv, input logic st, input logic up,
                             output bit o, output bit u);
      o = 1'b0;
      u = 1'b0;
      if (ld) m = clampval(lv, r);
      else if (st && up) begin
         if (m == maxv(r)) begin o = 1'b1; if (wrap) m = 0; end
         else m = m + 1;
      end else if (st) begin
         if (m == 0) begin u = 1'b1; if (wrap) m = maxv(r); end
         else m = m - 1;
      end
   endtask

   task automatic apply(input logic ld, input logic [15:0] lv, input logic st, input logic up);
      load = ld; load_val = lv; step_valid = st; dir_up = up;
      @(posedge clk);
      model_step(m10, 10, 1'b1, ld, lv, st, up, eo10, eu10);
      model_step(m16, 16, 1'b0, ld, lv, st, up, eo16, eu16);
      @(negedge clk);
      load = 1'b0; step_valid = 1'b0;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_cnt10"}, count_d, enc(m10, 10));
      check({tag, "_ovf10"}, ovf_d, eo10);
      check({tag, "_unf10"}, unf_d, eu10);
      check({tag, "_cnt16"}, count_h, enc(m16, 16));
      check({tag, "_ovf16"}, ovf_h, eo16);
      check({tag, "_unf16"}, unf_h, eu16);
   endtask

   task automatic disp_check(input string tag);
      int slot, k;
      logic [3:0] ean;
      repeat (16) apply(1'b0, 16'h0, 1'b0, 1'b0);
      for (int n = 0; n < 16; n++) begin
         apply(1'b0, 16'h0, 1'b0, 1'b0);
         slot = cyc / SD;
         k    = (slot - 1) % 4;
         ean  = 4'b1111 & ~(4'b0001 << k);
         check({tag, "_an10"}, an_d, ean);
         check({tag, "_seg10"}, seg_d, exp_seg(enc(m10, 10), k));
         check({tag, "_an16"}, an_h, ean);
         check({tag, "_seg16"}, seg_h, exp_seg(enc(m16, 16), k));
         check({tag, "_dp"}, {dp_d, dp_h}, 2'b11);
      end
   endtask

   initial begin
      tbl[0]  = '{1'b1, 16'h0099, 1'b0, 1'b0, 16'h0099, 1'b0, 1'b0, 16'h0099, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h009A, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 16'h9999, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h999A, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h999A, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 16'h00A7, 1'b1, 1'b1, 16'h0097, 1'b0, 1'b0, 16'h00A7, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0098, 1'b0, 1'b0, 16'h00A8, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b1, 16'hFFFD, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 16'h1200, 1'b0, 1'b0, 16'h1200, 1'b0, 1'b0, 16'h1200, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1199, 1'b0, 1'b0, 16'h11FF, 1'b0, 1'b0};
      tbl[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h1199, 1'b0, 1'b0, 16'h11FF, 1'b0, 1'b0};
      tbl[18] = '{1'b1, 16'hC5B0, 1'b1, 1'b0, 16'h9590, 1'b0, 1'b0, 16'hC5B0, 1'b0, 1'b0};
      tbl[19] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h9589, 1'b0, 1'b0, 16'hC5AF, 1'b0, 1'b0};

      res = 1'b1; load = 1'b0; load_val = '0; step_valid = 1'b0; dir_up = 1'b0;
      m10 = 3; m16 = 3; eo10 = 0; eu10 = 0; eo16 = 0; eu16 = 0;

      repeat (2) @(negedge clk);
      check("rst_cnt10", count_d, 16'h0003);
      check("rst_cnt16", count_h, 16'h0003);
      check("rst_flags", {ovf_d, unf_d, ovf_h, unf_h}, 4'b0000);
      check("rst_an", {an_d, an_h}, 8'hFF);
      check("rst_seg", {seg_d, seg_h}, 14'h3FFF);
      check("rst_dp", {dp_d, dp_h}, 2'b11);

      res = 1'b0;
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, 16'h0, 1'b0, 1'b0);
         if (i < 3) begin
            check("first_an_dark10", an_d, 4'b1111);
            check("first_an_dark16", an_h, 4'b1111);
         end else begin
            check("first_an10", an_d, 4'b1110);
            check("first_seg10", seg_d, 7'b0000110);
            check("first_an16", an_h, 4'b1110);
            check("first_seg16", seg_h, 7'b0000110);
         end
      end

      foreach (tbl[i]) begin
         apply(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].up);
         check($sformatf("tbl%0d_cnt10", i), count_d, tbl[i].ed);
         check($sformatf("tbl%0d_flg10", i), {ovf_d, unf_d}, {tbl[i].od, tbl[i].ud});
         check($sformatf("tbl%0d_cnt16", i), count_h, tbl[i].eh);
         check($sformatf("tbl%0d_flg16", i), {ovf_h, unf_h}, {tbl[i].oh, tbl[i].uh});
      end
      disp_check("disp_tbl");

      apply(1'b1, 16'h00A7, 1'b1, 1'b1);
      check("ldstep_cnt10", count_d, 16'h0097);
      check("ldstep_cnt16", count_h, 16'h00A7);
      disp_check("disp_a7");

      apply(1'b1, 16'h00FF, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) apply(1'b0, 16'h0, 1'b1, 1'b1);
      check("hex20_cnt16", count_h, 16'h0113);
      check("hex20_cnt10", count_d, 16'h0119);
      apply(1'b0, 16'h0, 1'b1, 1'b1);
      step_valid = 1'b1; dir_up = 1'b1;
      #2 res = 1'b1;
      #1;
      m10 = 3; m16 = 3; eo10 = 0; eu10 = 0; eo16 = 0; eu16 = 0;
      check("async_cnt10", count_d, 16'h0003);
      check("async_cnt16", count_h, 16'h0003);
      check("async_an", {an_d, an_h}, 8'hFF);
      check("async_seg", {seg_d, seg_h}, 14'h3FFF);
      @(negedge clk);
      step_valid = 1'b0;
      res = 1'b0;
      check_model("post_rst");
      disp_check("disp_rst");

      for (int n = 0; n < 400; n++) begin
         logic [15:0] lv;
         case ($urandom_range(3))
            0: lv = 16'($urandom);
            1: lv = 16'h9999;
            2: lv = 16'h0000;
            default: lv = 16'hFFFF;
         endcase
         apply($urandom_range(7) == 0, lv, 1'($urandom_range(1)), 1'($urandom_range(1)));
         check_model($sformatf("rnd%0d", n));
      end
      disp_check("disp_rnd");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
